// File: rtl/uart_rx_ctrl.sv
// Receive controller for uart_rx: byte FIFO, DATA/STATUS/CTRL/COUNT registers, level IRQ.
// Optional idle timeout flag is compiled in when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH     = 16,
  parameter int IRQ_THRESHOLD  = 1,
  parameter int TIMEOUT_CYCLES = 8680
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       bus_cs,
  input  logic       bus_we,
  input  logic [1:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_COUNT  = 2'd3
  } reg_addr_e;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          ie_q, ie_d;
  logic          irq_q, irq_d;
  logic          rx_ready_q;
  logic          timeout_q;

  reg_addr_e addr;
  logic      wr_acc, rd_acc, empty, full, push_edge, flush, pop_ok, push_ok, overrun_set, st_w1c;

  assign addr        = reg_addr_e'(bus_addr);
  assign wr_acc      = bus_cs & bus_we;
  assign rd_acc      = bus_cs & ~bus_we;
  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign push_edge   = rx_ready & ~rx_ready_q;
  assign flush       = wr_acc & (addr == REG_CTRL) & bus_wdata[1];
  assign st_w1c      = wr_acc & (addr == REG_STATUS);
  assign pop_ok      = rd_acc & (addr == REG_DATA) & ~empty;
  // A pop in the same clk frees the slot, so a full FIFO still accepts the byte.
  assign push_ok     = push_edge & ~flush & (~full | pop_ok);
  assign overrun_set = push_edge & ~flush & full & ~pop_ok;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    ie_d      = ie_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      if (st_w1c && bus_wdata[2]) overrun_d = 1'b0;
      if (overrun_set)            overrun_d = 1'b1;
    end
    if (wr_acc && addr == REG_CTRL) ie_d = bus_wdata[0];
    irq_d = ie_q & ((count_q >= CW'(IRQ_THRESHOLD)) | overrun_q | timeout_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      ie_q       <= 1'b0;
      irq_q      <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      ie_q       <= ie_d;
      irq_q      <= irq_d;
      rx_ready_q <= rx_ready;
    end
  end

  // NOTE: storage is not reset; count/pointers define validity and empty reads return 0x00.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= rx_data;
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_q, idle_d;
  logic          timeout_d;

  always_comb begin
    idle_d    = idle_q;
    timeout_d = timeout_q;
    if (push_ok || pop_ok || flush || empty) idle_d = '0;
    else if (idle_q != IW'(TIMEOUT_CYCLES))  idle_d = idle_q + 1'b1;
    if (flush) begin
      timeout_d = 1'b0;
    end else begin
      if (st_w1c && bus_wdata[3]) timeout_d = 1'b0;
      // Set only on the transition into the limit; a held counter must not re-arm a cleared flag.
      if (idle_q != IW'(TIMEOUT_CYCLES) && idle_d == IW'(TIMEOUT_CYCLES)) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign timeout_q = 1'b0;
`endif

  always_comb begin
    bus_rdata = 8'h00;
    if (bus_cs) begin
      case (addr)
        REG_DATA:   bus_rdata = empty ? 8'h00 : mem[rd_ptr_q];
        REG_STATUS: bus_rdata = {4'b0, timeout_q, overrun_q, full, ~empty};
        REG_CTRL:   bus_rdata = {7'b0, ie_q};
        REG_COUNT:  bus_rdata = 8'(count_q);
        default:    bus_rdata = 8'h00;
      endcase
    end
  end

  assign irq = irq_q;

endmodule
